// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM types plus the multicore RAM arbiter types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Wide enough for the largest supported core count (4).
    localparam int ARB_IDX_W = 2;
    localparam int ARB_MAXN  = 1 << ARB_IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_I  = 2'd0,
        SRC_DR = 2'd1,
        SRC_DW = 2'd2
    } arb_src_t;

    typedef struct packed {
        logic [ARB_IDX_W-1:0] idx;
        arb_src_t             src;
        word_t                addr;
        word_t                data;
    } arb_grant_t;

    function automatic logic [ARB_IDX_W-1:0] rr_wrap(
        input logic [ARB_IDX_W-1:0] base,
        input int                   off,
        input int                   n
    );
        int s;
        s = int'(base) + off;
        if (s >= n) s = s - n;
        return ARB_IDX_W'(s);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker: first requester at or after ptr
module rr_picker
    import cpu_types_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]           req,
    input  logic [ARB_IDX_W-1:0]   ptr,
    output logic                   valid,
    output logic [ARB_IDX_W-1:0]   idx
);

    logic [ARB_MAXN-1:0] req_x;

    // Walk offsets from far to near so the nearest requester is the last assignment.
    always_comb begin
        req_x = ARB_MAXN'(req);
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_x[rr_wrap(ptr, k, N)]) begin
                valid = 1'b1;
                idx   = rr_wrap(ptr, k, N);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin RAM port arbiter for CPUS I/D cache pairs; optional RAM_ARB_STATS_EN
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   iaddr,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   iload,
    output logic [CPUS*32-1:0]   dload,
    input  word_t                ramload,
    input  ramstate_t            ramstate,
    output word_t                ramaddr,
    output word_t                ramstore,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic                 timeout
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [(CPUS+1)*32-1:0] arb_stats
`endif
);

    localparam logic [7:0] TMAX = 8'(TIMEOUT);

    arb_state_t             state, state_nxt;
    arb_grant_t             grant, grant_nxt;
    logic [ARB_IDX_W-1:0]   rr_ptr, ptr_adv, pick_idx;
    logic                   pick_valid;
    logic [7:0]             timer;
    logic                   is_issue, hit, abort;

    logic [ARB_MAXN-1:0]    iren_x, dren_x, dwen_x;
    word_t                  iaddr_a  [ARB_MAXN];
    word_t                  daddr_a  [ARB_MAXN];
    word_t                  dstore_a [ARB_MAXN];

    // Zero-extend per-CPU buses to the fixed index range so a grant index selects directly.
    always_comb begin
        iren_x = ARB_MAXN'(iREN);
        dren_x = ARB_MAXN'(dREN);
        dwen_x = ARB_MAXN'(dWEN);
        for (int i = 0; i < ARB_MAXN; i++) begin
            iaddr_a[i]  = '0;
            daddr_a[i]  = '0;
            dstore_a[i] = '0;
        end
        for (int i = 0; i < CPUS; i++) begin
            iaddr_a[i]  = iaddr[i*32 +: 32];
            daddr_a[i]  = daddr[i*32 +: 32];
            dstore_a[i] = dstore[i*32 +: 32];
        end
    end

    rr_picker #(.N(CPUS)) u_pick (
        .req   (iREN | dREN | dWEN),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        grant_nxt.idx = pick_idx;
        if (dwen_x[pick_idx])      grant_nxt.src = SRC_DW;
        else if (dren_x[pick_idx]) grant_nxt.src = SRC_DR;
        else                       grant_nxt.src = SRC_I;
        grant_nxt.addr = (grant_nxt.src == SRC_I) ? iaddr_a[pick_idx] : daddr_a[pick_idx];
        grant_nxt.data = dstore_a[pick_idx];
    end

    assign is_issue = (state == ISSUE);
    assign hit      = is_issue && (ramstate == ACCESS);
    assign abort    = is_issue && !hit && ((ramstate == ERROR) || (timer == TMAX));
    assign ptr_adv  = rr_wrap(grant.idx, 1, CPUS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE:   if (hit)        state_nxt = DONE;
                     else if (abort) state_nxt = IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            grant  <= '0;
            rr_ptr <= '0;
            timer  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= grant_nxt;
                        timer <= '0;
                    end
                end
                ISSUE: begin
                    if (hit || abort) rr_ptr <= ptr_adv;
                    else              timer  <= timer + 8'd1;
                end
                DONE:    timer <= '0;
                default: timer <= '0;
            endcase
        end
    end

    // Waits are cut combinationally from ramstate so the requester sees ACCESS in the same cycle.
    always_comb begin
        ramREN   = is_issue && (grant.src != SRC_DW);
        ramWEN   = is_issue && (grant.src == SRC_DW);
        ramaddr  = is_issue ? grant.addr : '0;
        ramstore = is_issue ? grant.data : '0;
        timeout  = abort;
        iwait    = '1;
        dwait    = '1;
        for (int i = 0; i < CPUS; i++) begin
            if (hit && (grant.idx == ARB_IDX_W'(i))) begin
                if (grant.src == SRC_I) iwait[i] = 1'b0;
                else                    dwait[i] = 1'b0;
            end
        end
        iload = {CPUS{ramload}};
        dload = {CPUS{ramload}};
    end

`ifdef RAM_ARB_STATS_EN
    logic [31:0] grant_cnt [CPUS];
    logic [31:0] stall_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < CPUS; i++) grant_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < CPUS; i++) begin
                if ((state == IDLE) && pick_valid && (pick_idx == ARB_IDX_W'(i)))
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
            end
            if (is_issue && (ramstate == BUSY)) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_comb begin
        arb_stats = '0;
        for (int i = 0; i < CPUS; i++) arb_stats[i*32 +: 32] = grant_cnt[i];
        arb_stats[CPUS*32 +: 32] = stall_cnt;
    end
`endif

endmodule
